// File: rtl/rounding_pkg.sv
// ----------------------------------------------------------------------------
// rounding_pkg
//   Defaults shared by the rounding operand encoder and the downstream rounding
//   mux, so both ends of the interface agree on operand and exponent widths.
//   Contents:
//     clog2          - constant function, ceil(log2(value)); 0 for value <= 1
//     WIDTH_DEF      - default operand / one-hot width
//     LOG2_WIDTH_DEF - default exponent width, derived from WIDTH_DEF
// ----------------------------------------------------------------------------
package rounding_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        r = 0;
        if (value > 1) begin
            v = value - 1;
            while (v > 0) begin
                v = v >> 1;
                r = r + 1;
            end
        end
        return r;
    endfunction

    localparam int unsigned WIDTH_DEF      = 16;
    localparam int unsigned LOG2_WIDTH_DEF = clog2(WIDTH_DEF);

endpackage

// File: rtl/leading_one_detector.sv
// ----------------------------------------------------------------------------
// leading_one_detector
//   Combinational priority encoder: reports the index of the most significant
//   set bit of data_i, plus a flag for an all-zero input (index reads 0 then).
//   Ports:
//     data_i   [WIDTH-1:0]       operand to scan
//     index_o  [LOG2_WIDTH-1:0]  position of the leading one
//     zero_o                     data_i is all zeros
// ----------------------------------------------------------------------------
module leading_one_detector
    import rounding_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned LOG2_WIDTH = LOG2_WIDTH_DEF
) (
    input  logic [WIDTH-1:0]      data_i,
    output logic [LOG2_WIDTH-1:0] index_o,
    output logic                  zero_o
);

    // Ascending scan: later (higher) set bits overwrite earlier ones, so the
    // last hit is the most significant one.
    always_comb begin
        index_o = '0;
        zero_o  = 1'b1;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (data_i[i]) begin
                index_o = LOG2_WIDTH'(i);
                zero_o  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rounding_operand_encoder.sv
// ----------------------------------------------------------------------------
// rounding_operand_encoder
//   Producer side of the rounding-mux interface. For an unsigned operand with
//   leading one at position k it emits IN = 2**k, the rounding decision bit
//   operand[k-1], the exponent k and a zero flag. Two-stage pipeline with
//   valid/ready on both sides, one operand per cycle at full throughput.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     in_valid/in_ready input handshake
//     operand           unsigned multiplicand
//     out_valid/out_ready output handshake
//     pow2_out          one-hot 2**k (zero for a zero operand)
//     decision_bit      operand[k-1]; 0 when k==0 or operand==0
//     exp_out           k; 0 for a zero operand
//     zero_out          operand was zero
// ----------------------------------------------------------------------------
module rounding_operand_encoder
    import rounding_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned LOG2_WIDTH = LOG2_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      operand,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      pow2_out,
    output logic                  decision_bit,
    output logic [LOG2_WIDTH-1:0] exp_out,
    output logic                  zero_out
);

    // Stage 1: captured operand with its leading-one index.
    logic                  s1_valid_q;
    logic [WIDTH-1:0]      s1_operand_q;
    logic [LOG2_WIDTH-1:0] s1_exp_q;
    logic                  s1_zero_q;

    // Stage 2: decoded outputs.
    logic                  s2_valid_q;
    logic [WIDTH-1:0]      s2_pow2_q;
    logic                  s2_decision_q;
    logic [LOG2_WIDTH-1:0] s2_exp_q;
    logic                  s2_zero_q;

    logic [LOG2_WIDTH-1:0] lod_index;
    logic                  lod_zero;

    logic                  s1_load;
    logic                  s2_load;
    logic                  in_xfer;

    logic [WIDTH-1:0]      s2_pow2_d;
    logic                  s2_decision_d;
    logic [LOG2_WIDTH-1:0] below_idx;

    leading_one_detector #(
        .WIDTH      (WIDTH),
        .LOG2_WIDTH (LOG2_WIDTH)
    ) u_lod (
        .data_i  (operand),
        .index_o (lod_index),
        .zero_o  (lod_zero)
    );

    // A stage advances when it is empty or its contents move on this cycle;
    // in_ready follows out_ready combinationally so a full pipe with a
    // consuming sink still accepts every cycle.
    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load;
    assign in_xfer  = in_valid && in_ready;

    // below_idx wraps when k==0; the k!=0 term masks that case out.
    assign below_idx     = s1_exp_q - LOG2_WIDTH'(1);
    assign s2_decision_d = !s1_zero_q && (s1_exp_q != '0) && s1_operand_q[below_idx];
    assign s2_pow2_d     = s1_zero_q ? '0 : (WIDTH'(1) << s1_exp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_operand_q  <= '0;
            s1_exp_q      <= '0;
            s1_zero_q     <= 1'b0;
            s2_valid_q    <= 1'b0;
            s2_pow2_q     <= '0;
            s2_decision_q <= 1'b0;
            s2_exp_q      <= '0;
            s2_zero_q     <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid_q <= in_valid;
            end
            // Data registers only move on a real transfer; bubbles leave
            // them stale, which is harmless because valid gates them.
            if (in_xfer) begin
                s1_operand_q <= operand;
                s1_exp_q     <= lod_index;
                s1_zero_q    <= lod_zero;
            end
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_pow2_q     <= s2_pow2_d;
                    s2_decision_q <= s2_decision_d;
                    s2_exp_q      <= s1_exp_q;
                    s2_zero_q     <= s1_zero_q;
                end
            end
        end
    end

    assign out_valid    = s2_valid_q;
    assign pow2_out     = s2_pow2_q;
    assign decision_bit = s2_decision_q;
    assign exp_out      = s2_exp_q;
    assign zero_out     = s2_zero_q;

endmodule

// File: tb/tb_rounding_operand_encoder.sv
module tb_rounding_operand_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] operand;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pow2_out;
    logic        decision_bit;
    logic [3:0]  exp_out;
    logic        zero_out;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_out    = 0;

    bit          mon_en = 0;
    logic [15:0] sb[$];

    bit          stall_prev = 0;
    logic [15:0] h_pow2;
    logic        h_dec;
    logic [3:0]  h_exp;
    logic        h_zero;

    rounding_operand_encoder #(.WIDTH(16), .LOG2_WIDTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .operand      (operand),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pow2_out     (pow2_out),
        .decision_bit (decision_bit),
        .exp_out      (exp_out),
        .zero_out     (zero_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: k = floor(log2 x) by repeated halving; round up when the
    // remainder above 2**k reaches half of 2**k.
    function automatic void model(input logic [15:0] x, output logic [15:0] p,
                                  output logic d, output logic [3:0] k,
                                  output logic z, output logic [16:0] r);
        int v;
        int kk;
        int pw;
        v  = int'(x);
        kk = 0;
        if (v == 0) begin
            p = 16'h0; d = 1'b0; k = 4'd0; z = 1'b1; r = 17'h0;
        end else begin
            while (v > 1) begin
                v  = v / 2;
                kk = kk + 1;
            end
            pw = 1 << kk;
            p  = 16'(pw);
            d  = (kk > 0) && ((int'(x) - pw) >= (pw / 2));
            k  = 4'(kk);
            z  = 1'b0;
            r  = d ? 17'(2 * pw) : 17'(pw);
        end
    endfunction

    function automatic logic [15:0] rand_op();
        logic [15:0] v;
        v = 16'($urandom);
        case ($urandom_range(0, 4))
            0: rand_op = v;
            1: rand_op = 16'(1 << $urandom_range(0, 15));
            2: rand_op = v & 16'h00FF;
            3: rand_op = v >> $urandom_range(0, 15);
            default: rand_op = v & 16'(($urandom_range(0, 3) == 0) ? 0 : 16'hFFFF);
        endcase
    endfunction

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [15:0] x, ep;
        logic        ed, ez;
        logic [3:0]  ek;
        logic [16:0] er, mux_out;
        if (!rst_n || !mon_en) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_pow2", pow2_out, h_pow2);
                chk("hold_dec", decision_bit, h_dec);
                chk("hold_exp", exp_out, h_exp);
                chk("hold_zero", zero_out, h_zero);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_extra_output", 1, 0);
                end else begin
                    x = sb.pop_front();
                    model(x, ep, ed, ek, ez, er);
                    chk("sb_pow2", pow2_out, ep);
                    chk("sb_dec", decision_bit, ed);
                    chk("sb_exp", exp_out, ek);
                    chk("sb_zero", zero_out, ez);
                    mux_out = decision_bit ? {pow2_out, 1'b0} : {1'b0, pow2_out};
                    chk("sb_mux_round", mux_out, er);
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(operand);
                n_acc++;
            end
            stall_prev = out_valid && !out_ready;
            h_pow2 = pow2_out;
            h_dec  = decision_bit;
            h_exp  = exp_out;
            h_zero = zero_out;
        end
    end

    task automatic send_one(input string tag, input logic [15:0] x, input logic [15:0] ep,
                            input logic ed, input logic [3:0] ek, input logic ez);
        operand   = x;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, out_valid, 0);
        @(posedge clk);
        #1;
        chk({tag, "_lat2_valid"}, out_valid, 1);
        chk({tag, "_pow2"}, pow2_out, ep);
        chk({tag, "_dec"}, decision_bit, ed);
        chk({tag, "_exp"}, exp_out, ek);
        chk({tag, "_zero"}, zero_out, ez);
    endtask

    task automatic drain(input string tag, input int expect_out);
        int budget;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        budget    = 0;
        while (n_out < expect_out && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        @(posedge clk);
        #1;
        chk({tag, "_out_count"}, n_out, expect_out);
        chk({tag, "_sb_empty"}, sb.size(), 0);
        chk({tag, "_idle"}, out_valid, 0);
    endtask

    initial begin
        bit took;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operand   = 16'h0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pow2", pow2_out, 0);
        chk("rst_dec", decision_bit, 0);
        chk("rst_exp", exp_out, 0);
        chk("rst_zero", zero_out, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);

        // Directed encodings
        send_one("enc_00B4", 16'h00B4, 16'h0080, 1'b0, 4'd7, 1'b0);
        send_one("enc_00C0", 16'h00C0, 16'h0080, 1'b1, 4'd7, 1'b0);
        send_one("enc_0001", 16'h0001, 16'h0001, 1'b0, 4'd0, 1'b0);
        send_one("enc_C000", 16'hC000, 16'h8000, 1'b1, 4'd15, 1'b0);
        send_one("enc_8000", 16'h8000, 16'h8000, 1'b0, 4'd15, 1'b0);
        send_one("enc_0000", 16'h0000, 16'h0000, 1'b0, 4'd0, 1'b1);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        operand   = 16'hFFFF;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("midrst_full_valid", out_valid, 1);
        chk("midrst_full_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_pow2", pow2_out, 0);
        chk("midrst_dec", decision_bit, 0);
        chk("midrst_exp", exp_out, 0);
        chk("midrst_zero", zero_out, 0);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_no_replay", out_valid, 0);
        send_one("post_rst_0003", 16'h0003, 16'h0002, 1'b1, 4'd1, 1'b0);
        @(posedge clk);
        #1;
        chk("post_rst_single", out_valid, 0);

        // Throughput: 100 operands back to back
        sb.delete();
        n_acc  = 0;
        n_out  = 0;
        mon_en = 1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            operand  = rand_op();
            in_valid = 1'b1;
            #1;
            chk("tput_in_ready", in_ready, 1);
            if (i >= 2) chk("tput_out_valid", out_valid, 1);
            @(posedge clk);
            #1;
        end
        chk("tput_acc", n_acc, 100);
        drain("tput", 100);

        // Backpressure: pipe holds two, then stalls
        n_acc = 0;
        n_out = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            operand  = rand_op();
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("bp_accepted", n_acc, 2);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        drain("bp", 2);

        // Random handshakes on both sides
        n_acc = 0;
        n_out = 0;
        in_valid = 1'b0;
        took = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 99) < 70);
                operand  = rand_op();
            end
            out_ready = ($urandom_range(0, 99) < 65);
            #2;
            took = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        chk("rand_activity", (n_acc > 1000), 1);
        drain("rand", n_acc);
        mon_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
